key_sbox_arbiter: RTL

- Shares one 32-bit two-share key S-box array (8 nibble-wise threshold-implementation S-boxes, pipelined) between two requesters.
- Requester 0 is the key-schedule sequencer; requester 1 is the auxiliary/precompute path.
- The block does round-robin arbitration, registers the array inputs, tracks the owner of each in-flight word through the array latency, and returns results to the correct requester.
- Shares are never recombined inside this block.

---
 rtl/key_sbox_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/key_sbox_arbiter.sv
// Round-robin front end for a shared two-share nibble S-box array.
// Owner tags ride alongside the array latency so each result returns to the requester that issued it.
module key_sbox_arbiter #(
  parameter int SBOX_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_share0,
  input  logic [31:0] req0_share1,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_share0,
  input  logic [31:0] req1_share1,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_share0,
  output logic [31:0] rsp_share1,
  output logic [31:0] sbox_in0,
  output logic [31:0] sbox_in1,
  input  logic [31:0] sbox_out0,
  input  logic [31:0] sbox_out1,
  output logic        busy
);

  logic                  ptr;
  logic                  gnt_any;
  logic                  gnt_idx;
  logic [SBOX_LATENCY:0] vld_pipe;
  logic [SBOX_LATENCY:0] own_pipe;

  // Ready is gated by reset so every output reads 0 while rst_n is low.
  always_comb begin
    gnt_any = rst_n & (req0_valid | req1_valid);
    gnt_idx = (req0_valid & req1_valid) ? ptr : req1_valid;
  end

  assign req0_ready = gnt_any & ~gnt_idx;
  assign req1_ready = gnt_any & gnt_idx;
  assign busy       = gnt_any | (|vld_pipe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 1'b0;
      sbox_in0   <= '0;
      sbox_in1   <= '0;
      vld_pipe   <= '0;
      own_pipe   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_share0 <= '0;
      rsp_share1 <= '0;
    end else begin
      // Array inputs only move on a transfer so idle cycles cause no toggling.
      if (gnt_any) begin
        ptr      <= ~gnt_idx;
        sbox_in0 <= gnt_idx ? req1_share0 : req0_share0;
        sbox_in1 <= gnt_idx ? req1_share1 : req0_share1;
      end
      vld_pipe   <= {vld_pipe[SBOX_LATENCY-1:0], gnt_any};
      own_pipe   <= {own_pipe[SBOX_LATENCY-1:0], gnt_idx};
      rsp0_valid <= vld_pipe[SBOX_LATENCY] & ~own_pipe[SBOX_LATENCY];
      rsp1_valid <= vld_pipe[SBOX_LATENCY] &  own_pipe[SBOX_LATENCY];
      if (vld_pipe[SBOX_LATENCY]) begin
        rsp_share0 <= sbox_out0;
        rsp_share1 <= sbox_out1;
      end
    end
  end

endmodule
